// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers {frame_err, data} entries for the APB read path.
// Show-ahead head output, occupancy, level interrupt and sticky overrun.
module uart_rx_fifo #(
    parameter int data_bits = 8,
    parameter int depth     = 16,
    parameter int ptr_w     = 4
) (
    input  logic                 clk,
    input  logic                 PRESETn,
    input  logic                 clr,
    input  logic                 rx_done,
    input  logic [data_bits-1:0] rx_data,
    input  logic                 rx_error,
    input  logic                 rd_en,
    input  logic [ptr_w:0]       thresh,
    input  logic                 ovr_clr,
    output logic [data_bits-1:0] rd_data,
    output logic                 rd_err,
    output logic                 empty,
    output logic                 full,
    output logic [ptr_w:0]       count,
    output logic                 thresh_hit,
    output logic                 overrun
);

    localparam logic [ptr_w:0]   DEPTH_C = (ptr_w+1)'(depth);
    localparam logic [ptr_w:0]   CNT_ONE = (ptr_w+1)'(1);
    localparam logic [ptr_w-1:0] PTR_ONE = ptr_w'(1);

    logic [data_bits:0] mem_q [depth];

    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_w:0]   count_q, count_d;
    logic             overrun_q, overrun_d;

    logic push;
    logic pop;
    logic wr_en;
    logic drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign push  = rx_done | rx_error;
    assign pop   = rd_en & ~empty;

    // Next-state: flush beats traffic; a full push only lands if a pop frees the slot.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        wr_en     = 1'b0;
        drop      = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push && (!full || pop)) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (push && full && !pop) begin
                drop = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (wr_en && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !wr_en) begin
                count_d = count_q - CNT_ONE;
            end
        end
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    // Pointer, count and overrun registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!PRESETn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; contents are not reset, validity comes from count.
    always_ff @(posedge clk) begin
        if (PRESETn && wr_en) begin
            mem_q[wr_ptr_q] <= {rx_error, rx_data};
        end
    end

    // Show-ahead head entry, forced to zero when nothing is held.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if (!empty) begin
            rd_data = mem_q[rd_ptr_q][data_bits-1:0];
            rd_err  = mem_q[rd_ptr_q][data_bits];
        end
    end

    assign count      = count_q;
    assign overrun    = overrun_q;
    assign thresh_hit = (thresh != '0) && (count_q >= thresh);

endmodule
